// File: rtl/router_pkg.sv
// Shared definitions for the router output-channel FIFO: default widths,
// the stored word layout and the occupancy-counter width helper.
package router_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int LEN_LSB_DEF = 2;
  localparam int LEN_MSB_DEF = 7;

  // Stored FIFO word at the default data width: header flag above the byte.
  typedef struct packed {
    logic                  lfd;
    logic [DATA_W_DEF-1:0] data;
  } fifo_word_t;

  // Width needed to hold an occupancy of 0..depth inclusive.
  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/router_pkt_len_tracker.sv
// Read-side packet length tracker. Loads the remaining byte count from each
// popped header, counts payload/parity bytes down, and flags the parity byte
// (eop) and framing errors (pkt_err) in step with the registered dout.
module router_pkt_len_tracker
  import router_pkg::*;
#(
  parameter int LEN_W = LEN_MSB_DEF - LEN_LSB_DEF + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             pop,
  input  logic             pop_lfd,
  input  logic [LEN_W-1:0] pop_len,
  output logic             eop,
  output logic             pkt_err
);

  // One extra bit so payload length + parity never overflows.
  localparam int REM_W = LEN_W + 1;

  logic [REM_W-1:0] rem;

  // Remaining-bytes counter plus the per-pop eop/error flags.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rem     <= '0;
      eop     <= 1'b0;
      pkt_err <= 1'b0;
    end else if (pop) begin
      if (pop_lfd) begin
        rem     <= {1'b0, pop_len} + REM_W'(1);
        eop     <= 1'b0;
        pkt_err <= (rem != '0);
      end else if (rem != '0) begin
        rem     <= rem - REM_W'(1);
        eop     <= (rem == REM_W'(1));
        pkt_err <= 1'b0;
      end else begin
        eop     <= 1'b0;
        pkt_err <= 1'b1;
      end
    end else begin
      eop     <= 1'b0;
      pkt_err <= 1'b0;
    end
  end

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware FIFO for one router output channel. Stores {lfd, data} per
// entry, keeps a registered occupancy count, presents registered read data
// with header/end-of-packet/error flags, and optionally self-flushes when
// the destination stops reading (macro ROUTER_FIFO_TIMEOUT_EN).
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = 16,
  parameter int AFULL_TH = 12,
  parameter int LEN_LSB  = LEN_LSB_DEF,
  parameter int LEN_MSB  = LEN_MSB_DEF,
  parameter int TIMEOUT  = 30
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      soft_rst,
  input  logic                      wr_en,
  input  logic                      lfd_state,
  input  logic [DATA_W-1:0]         din,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         dout,
  output logic                      dout_sof,
  output logic                      dout_eop,
  output logic                      pkt_err,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic [count_w(DEPTH)-1:0] count,
  output logic                      timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_w(DEPTH);

  logic [DATA_W:0] mem [DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic [DATA_W:0] rd_word;
  logic            flush_req, flush, wr_ok, rd_ok;

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= CW'(AFULL_TH));

  // A flush cycle (soft or timeout) accepts neither a read nor a write.
  assign flush   = soft_rst || flush_req;
  assign wr_ok   = wr_en && !full && !flush && !rst;
  assign rd_ok   = rd_en && !empty && !flush && !rst;
  assign rd_word = mem[rd_ptr[AW-1:0]];

  // Storage array written on accepted writes.
  // NOTE: the memory has no reset; contents are only meaningful between the
  // pointers, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= {lfd_state, din};
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered read data and header flag; both hold when no read occurs.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      dout     <= '0;
      dout_sof <= 1'b0;
    end else if (rd_ok) begin
      dout     <= rd_word[DATA_W-1:0];
      dout_sof <= rd_word[DATA_W];
    end
  end

  router_pkt_len_tracker #(
    .LEN_W (LEN_MSB - LEN_LSB + 1)
  ) u_len_tracker (
    .clk     (clk),
    .rst     (rst),
    .clear   (flush),
    .pop     (rd_ok),
    .pop_lfd (rd_word[DATA_W]),
    .pop_len (rd_word[LEN_MSB:LEN_LSB]),
    .eop     (dout_eop),
    .pkt_err (pkt_err)
  );

`ifdef ROUTER_FIFO_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);

  logic [IW-1:0] idle_cnt;

  assign flush_req = (idle_cnt == IW'(TIMEOUT - 1));

  // Counts cycles with data waiting and no read request.
  always_ff @(posedge clk) begin
    if (rst || flush || empty || rd_en) idle_cnt <= '0;
    else                                idle_cnt <= idle_cnt + IW'(1);
  end

  // One-cycle pulse marking the edge on which the auto-flush happened.
  always_ff @(posedge clk) begin
    if (rst || soft_rst) timeout <= 1'b0;
    else                 timeout <= flush_req;
  end
`else
  assign flush_req = 1'b0;
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Directed bench for router_pkt_fifo: fill/drain order, packet framing flags,
// simultaneous read/write at the boundaries, soft reset, pkt_err, and the
// optional idle-timeout flush (ROUTER_FIFO_TIMEOUT_EN).
module tb_router_pkt_fifo;
  import router_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0, soft_rst = 1'b0;
  logic       wr_en = 1'b0, lfd_state = 1'b0, rd_en = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       dout_sof, dout_eop, pkt_err, full, empty, almost_full, timeout;
  logic [4:0] count;

  int n_checks = 0;
  int n_errors = 0;

  router_pkt_fifo dut (
    .clk         (clk),
    .rst         (rst),
    .soft_rst    (soft_rst),
    .wr_en       (wr_en),
    .lfd_state   (lfd_state),
    .din         (din),
    .rd_en       (rd_en),
    .dout        (dout),
    .dout_sof    (dout_sof),
    .dout_eop    (dout_eop),
    .pkt_err     (pkt_err),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .count       (count),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus; outputs are sampled 1ns after the edge.
  task automatic cyc(input logic w, input logic l, input logic [7:0] d, input logic r);
    wr_en = w; lfd_state = l; din = d; rd_en = r;
    @(posedge clk); #1;
    wr_en = 1'b0; lfd_state = 1'b0; rd_en = 1'b0;
  endtask

  task automatic wr(input logic l, input logic [7:0] d);
    cyc(1'b1, l, d, 1'b0);
  endtask

  task automatic rd();
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic pulse_soft_rst();
    soft_rst = 1'b1;
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    soft_rst = 1'b0;
  endtask

  // Header, payload and parity bytes for the framing test.
  fifo_word_t pkt_a [5];

  initial begin
    pkt_a[0] = '{lfd: 1'b1, data: 8'h0C};
    pkt_a[1] = '{lfd: 1'b0, data: 8'hA1};
    pkt_a[2] = '{lfd: 1'b0, data: 8'hA2};
    pkt_a[3] = '{lfd: 1'b0, data: 8'hA3};
    pkt_a[4] = '{lfd: 1'b0, data: 8'h55};

    // ---- reset state
    rst = 1'b1;
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_dout", dout, 0);
    check("rst_flags", {dout_sof, dout_eop, pkt_err, timeout}, 0);

    // ---- 1: fill 16, overflow ignored, drain in order
    for (int i = 1; i <= 16; i++) begin
      wr(1'b0, 8'(i));
      if (i == 11) check("afull_below_th", almost_full, 0);
      if (i == 12) check("afull_at_th", almost_full, 1);
      if (i == 15) check("not_full_15", full, 0);
    end
    check("fill_full", full, 1);
    check("fill_count", count, 16);
    wr(1'b0, 8'hFF);
    check("overflow_count", count, 16);
    for (int i = 1; i <= 16; i++) begin
      rd();
      check($sformatf("drain_%0d", i), dout, i);
      if (i == 1) check("stray_err", pkt_err, 1);
    end
    check("drain_empty", empty, 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check("rd_empty_hold", dout, 8'h10);
    check("rd_empty_noerr", {dout_eop, pkt_err}, 0);

    // ---- 2: header len 3 + 3 payload + parity
    for (int i = 0; i < 5; i++) wr(pkt_a[i].lfd, pkt_a[i].data);
    for (int i = 0; i < 5; i++) begin
      rd();
      check($sformatf("pkt_dout_%0d", i), dout, pkt_a[i].data);
      check($sformatf("pkt_sof_%0d", i), dout_sof, (i == 0));
      check($sformatf("pkt_eop_%0d", i), dout_eop, (i == 4));
      check($sformatf("pkt_err_%0d", i), pkt_err, 0);
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check("eop_drops", dout_eop, 0);

    // ---- 3: simultaneous read/write at full and at empty
    for (int i = 0; i < 16; i++) wr(1'b0, 8'(8'h20 + i));
    cyc(1'b1, 1'b0, 8'hEE, 1'b1);
    check("full_rw_count", count, 15);
    check("full_rw_dout", dout, 8'h20);
    for (int i = 0; i < 15; i++) rd();
    check("full_rw_last", dout, 8'h2F);
    check("full_rw_empty", empty, 1);
    cyc(1'b1, 1'b0, 8'h77, 1'b1);
    check("empty_rw_count", count, 1);
    check("empty_rw_dout", dout, 8'h2F);
    rd();
    check("empty_rw_read", dout, 8'h77);

    // ---- 4: soft reset mid-read
    for (int i = 0; i < 6; i++) wr(1'b0, 8'(8'h31 + i));
    rd();
    rd();
    check("pre_srst_dout", dout, 8'h32);
    soft_rst = 1'b1;
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    soft_rst = 1'b0;
    check("srst_count", count, 0);
    check("srst_empty", empty, 1);
    check("srst_dout", dout, 0);
    wr(1'b1, 8'h5A);
    rd();
    check("post_srst_dout", dout, 8'h5A);
    check("post_srst_sof", dout_sof, 1);
    check("post_srst_err", pkt_err, 0);

    // ---- 5: header interrupted by new header, then zero-length header
    pulse_soft_rst();
    wr(1'b1, 8'h0C);
    wr(1'b0, 8'hB1);
    wr(1'b1, 8'h10);
    wr(1'b0, 8'hC1);
    wr(1'b0, 8'hC2);
    wr(1'b0, 8'hC3);
    wr(1'b0, 8'hC4);
    wr(1'b0, 8'hCC);
    rd(); check("h1_err", pkt_err, 0);
    rd(); check("b1_flags", {dout_sof, dout_eop, pkt_err}, 0);
    rd();
    check("h2_sof", dout_sof, 1);
    check("h2_err", pkt_err, 1);
    rd(); check("c1_err_drop", pkt_err, 0);
    rd();
    rd();
    rd(); check("c4_eop", dout_eop, 0);
    rd();
    check("par2_dout", dout, 8'hCC);
    check("par2_eop", dout_eop, 1);
    check("par2_err", pkt_err, 0);
    wr(1'b1, 8'h00);
    wr(1'b0, 8'h99);
    rd(); check("h0_flags", {dout_sof, dout_eop, pkt_err}, 3'b100);
    rd(); check("h0_parity_eop", {dout_sof, dout_eop, pkt_err}, 3'b010);

    // ---- 6: idle timeout
    pulse_soft_rst();
    wr(1'b0, 8'h42);
`ifdef ROUTER_FIFO_TIMEOUT_EN
    begin
      int hit = 0;
      for (int i = 1; i <= 40 && hit == 0; i++) begin
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        if (timeout) hit = i;
      end
      check("to_cycle", hit, 30);
      check("to_flushed", {empty, count}, {1'b1, 5'd0});
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      check("to_one_cycle", timeout, 0);
      check("to_still_empty", empty, 1);
    end
`else
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        seen = seen | timeout;
      end
      check("no_to_pulse", seen, 0);
      check("no_to_count", count, 1);
      rd();
      check("no_to_held", dout, 8'h42);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
